// File: rtl/bus_pkg.sv
// Shared bus types for the memory data-port arbiter: width encodings,
// requester payload and read-response routing tag.
package bus_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WIDTH_W = 2;

    localparam logic [WIDTH_W-1:0] WIDTH_BYTE = 2'd0;
    localparam logic [WIDTH_W-1:0] WIDTH_HALF = 2'd1;
    localparam logic [WIDTH_W-1:0] WIDTH_WORD = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
        logic [WIDTH_W-1:0] width;
        logic               we;
        logic               zeroextend;
        logic               lock;
    } bus_req_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } resp_tag_t;

endpackage

// File: rtl/resp_tag_pipe.sv
// Latency-matched shift register carrying {valid, owner} for each issued read,
// so returning data can be steered to the requester that issued it.
module resp_tag_pipe
    import bus_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      i_clk,
    input  logic      i_clr,
    input  resp_tag_t i_push,
    output resp_tag_t o_tag
);

    resp_tag_t stages [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= i_push;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign o_tag = stages[DEPTH-1];

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester arbiter for the memory_controller data port: combinational
// grant with fixed priority, starvation guard, bus lock and tagged read return.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [1:0]  i_m0_width,
    input  logic        i_m0_we,
    input  logic        i_m0_zeroextend,
    input  logic        i_m0_lock,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [1:0]  i_m1_width,
    input  logic        i_m1_we,
    input  logic        i_m1_zeroextend,
    input  logic        i_m1_lock,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [1:0]  o_s_width,
    output logic        o_s_we,
    output logic        o_s_read_en,
    output logic        o_s_zeroextend,
    input  logic [31:0] i_s_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    bus_req_t   m0, m1, sel;
    logic       any_gnt;
    logic       lock_valid, lock_valid_n;
    logic       lock_owner, lock_owner_n;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
    resp_tag_t  push_tag, tail_tag;

    assign m0 = '{addr: i_m0_addr, wdata: i_m0_wdata, width: i_m0_width,
                  we: i_m0_we, zeroextend: i_m0_zeroextend, lock: i_m0_lock};
    assign m1 = '{addr: i_m1_addr, wdata: i_m1_wdata, width: i_m1_width,
                  we: i_m1_we, zeroextend: i_m1_zeroextend, lock: i_m1_lock};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            starve_cnt <= '0;
        end else begin
            lock_valid <= lock_valid_n;
            lock_owner <= lock_owner_n;
            starve_cnt <= starve_cnt_n;
        end
    end

    // Grant selection and port mux; grants are held low through reset
    always_comb begin
        o_m0_gnt = 1'b0;
        o_m1_gnt = 1'b0;
        if (i_rst) begin
            o_m0_gnt = 1'b0;
        end else if (lock_valid) begin
            o_m0_gnt = i_m0_req & ~lock_owner;
            o_m1_gnt = i_m1_req &  lock_owner;
        end else if (i_m0_req && i_m1_req) begin
            o_m1_gnt = (starve_cnt == STARVE_MAX);
            o_m0_gnt = (starve_cnt != STARVE_MAX);
        end else begin
            o_m0_gnt = i_m0_req;
            o_m1_gnt = i_m1_req;
        end
        any_gnt        = o_m0_gnt | o_m1_gnt;
        sel            = o_m1_gnt ? m1 : m0;
        o_s_addr       = sel.addr;
        o_s_wdata      = sel.wdata;
        o_s_width      = sel.width;
        o_s_zeroextend = sel.zeroextend;
        o_s_we         = any_gnt &  sel.we;
        o_s_read_en    = any_gnt & ~sel.we;
    end

    // Next-state: lock tracking, starvation counter, response tag push
    always_comb begin
        lock_valid_n = lock_valid;
        lock_owner_n = lock_owner;
        starve_cnt_n = '0;
        push_tag     = '{valid: any_gnt & ~sel.we, owner: o_m1_gnt};
        if (lock_valid) begin
            if (lock_owner ? ~i_m1_lock : ~i_m0_lock) begin
                lock_valid_n = 1'b0;
            end
        end else if (any_gnt && sel.lock) begin
            lock_valid_n = 1'b1;
            lock_owner_n = o_m1_gnt;
        end
        if (i_m1_req && !o_m1_gnt) begin
            starve_cnt_n = (starve_cnt < STARVE_MAX) ? starve_cnt + CNT_W'(1) : starve_cnt;
        end
    end

    resp_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
        .i_clk  (i_clk),
        .i_clr  (i_rst),
        .i_push (push_tag),
        .o_tag  (tail_tag)
    );

    assign o_m0_rvalid = tail_tag.valid & ~tail_tag.owner & ~i_rst;
    assign o_m1_rvalid = tail_tag.valid &  tail_tag.owner & ~i_rst;
    assign o_m0_rdata  = i_s_rdata;
    assign o_m1_rdata  = i_s_rdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench: instance a (READ_LATENCY=1, STARVE_LIMIT=4) and instance b
// (READ_LATENCY=3, STARVE_LIMIT=8) share all requester stimulus.
module tb_data_bus_arbiter;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_ze, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic [1:0]  m0_width;
    logic        m1_req, m1_we, m1_ze, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [1:0]  m1_width;
    logic [31:0] s_rdata;

    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic [1:0]  a_s_width;
    logic        a_s_we, a_s_read_en, a_s_ze;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic [1:0]  b_s_width;
    logic        b_s_we, b_s_read_en, b_s_ze;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_width(m0_width),
        .i_m0_we(m0_we), .i_m0_zeroextend(m0_ze), .i_m0_lock(m0_lock),
        .o_m0_gnt(a_m0_gnt), .o_m0_rvalid(a_m0_rvalid), .o_m0_rdata(a_m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_width(m1_width),
        .i_m1_we(m1_we), .i_m1_zeroextend(m1_ze), .i_m1_lock(m1_lock),
        .o_m1_gnt(a_m1_gnt), .o_m1_rvalid(a_m1_rvalid), .o_m1_rdata(a_m1_rdata),
        .o_s_addr(a_s_addr), .o_s_wdata(a_s_wdata), .o_s_width(a_s_width), .o_s_we(a_s_we),
        .o_s_read_en(a_s_read_en), .o_s_zeroextend(a_s_ze), .i_s_rdata(s_rdata)
    );

    data_bus_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(8)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_width(m0_width),
        .i_m0_we(m0_we), .i_m0_zeroextend(m0_ze), .i_m0_lock(m0_lock),
        .o_m0_gnt(b_m0_gnt), .o_m0_rvalid(b_m0_rvalid), .o_m0_rdata(b_m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_width(m1_width),
        .i_m1_we(m1_we), .i_m1_zeroextend(m1_ze), .i_m1_lock(m1_lock),
        .o_m1_gnt(b_m1_gnt), .o_m1_rvalid(b_m1_rvalid), .o_m1_rdata(b_m1_rdata),
        .o_s_addr(b_s_addr), .o_s_wdata(b_s_wdata), .o_s_width(b_s_width), .o_s_we(b_s_we),
        .o_s_read_en(b_s_read_en), .o_s_zeroextend(b_s_ze), .i_s_rdata(s_rdata)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_ze = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_ze = 1'b0;
    endtask

    initial begin
        logic prev_m1;
        idle();
        m0_addr = '0; m0_wdata = '0; m0_width = WIDTH_WORD;
        m1_addr = '0; m1_wdata = '0; m1_width = WIDTH_WORD;
        s_rdata = '0;

        // Reset: grants and strobes held low even with a request present
        rst = 1'b1;
        m0_req = 1'b1;
        cycle();
        #1;
        chk1("rst_a_m0_gnt", a_m0_gnt, 1'b0);
        chk1("rst_b_m0_gnt", b_m0_gnt, 1'b0);
        chk1("rst_a_read_en", a_s_read_en, 1'b0);
        chk1("rst_a_we", a_s_we, 1'b0);
        chk1("rst_a_m0_rvalid", a_m0_rvalid, 1'b0);
        cycle();
        rst = 1'b0;
        idle();
        cycle();

        // Uncontested m0 read, zero added latency, data one cycle later
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h2000_0004; m0_ze = 1'b1;
        #1;
        chk1("t1_m0_gnt", a_m0_gnt, 1'b1);
        chk1("t1_m1_gnt", a_m1_gnt, 1'b0);
        chk1("t1_read_en", a_s_read_en, 1'b1);
        chk1("t1_we", a_s_we, 1'b0);
        chk32("t1_addr", a_s_addr, 32'h2000_0004);
        chk1("t1_ze", a_s_ze, 1'b1);
        cycle();
        idle();
        s_rdata = 32'hDEAD_BEEF;
        #1;
        chk1("t1_m0_rvalid", a_m0_rvalid, 1'b1);
        chk32("t1_m0_rdata", a_m0_rdata, 32'hDEAD_BEEF);
        chk1("t1_m1_rvalid", a_m1_rvalid, 1'b0);
        repeat (4) cycle();

        // Continuous contention: starvation guard rotates m1 in
        m0_req = 1'b1; m0_addr = 32'h2000_0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h2000_0200;
        prev_m1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk1("t2_a_m1_gnt", a_m1_gnt, (k % 5) == 4);
            chk1("t2_a_m0_gnt", a_m0_gnt, (k % 5) != 4);
            chk1("t2_b_m1_gnt", b_m1_gnt, k == 8);
            if (k > 0) begin
                chk1("t2_a_m1_rvalid", a_m1_rvalid, prev_m1);
                chk1("t2_a_m0_rvalid", a_m0_rvalid, ~prev_m1);
            end
            prev_m1 = ((k % 5) == 4);
            cycle();
        end
        idle();
        repeat (4) cycle();

        // m1 wins via starvation with lock, then holds the bus for 3 accesses
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h2000_0010;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
        m1_addr = 32'h2000_0000; m1_wdata = 32'h1122_3344;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk1("t3_pre_m0_gnt", a_m0_gnt, 1'b1);
            cycle();
        end
        #1;
        chk1("t3_w_m1_gnt", a_m1_gnt, 1'b1);
        chk1("t3_w_m0_gnt", a_m0_gnt, 1'b0);
        chk1("t3_w_we", a_s_we, 1'b1);
        chk32("t3_w_addr", a_s_addr, 32'h2000_0000);
        chk32("t3_w_wdata", a_s_wdata, 32'h1122_3344);
        cycle();
        m1_we = 1'b0; m1_addr = 32'h2000_0008;
        #1;
        chk1("t3_r_m1_gnt", a_m1_gnt, 1'b1);
        chk1("t3_r_m0_gnt", a_m0_gnt, 1'b0);
        chk1("t3_r_read_en", a_s_read_en, 1'b1);
        cycle();
        m1_we = 1'b1; m1_lock = 1'b0;
        #1;
        chk1("t3_rel_m1_rvalid", a_m1_rvalid, 1'b1);
        chk1("t3_rel_m1_gnt", a_m1_gnt, 1'b1);
        chk1("t3_rel_m0_gnt", a_m0_gnt, 1'b0);
        cycle();
        m1_we = 1'b0;
        #1;
        chk1("t3_after_m0_gnt", a_m0_gnt, 1'b1);
        chk1("t3_after_m1_gnt", a_m1_gnt, 1'b0);
        cycle();
        idle();
        repeat (5) cycle();

        // Alternating reads, issue-order return at both latencies
        for (int j = 0; j < 7; j++) begin
            idle();
            if (j == 0 || j == 2) begin
                m0_req = 1'b1; m0_addr = 32'h2000_0040 + 32'(j);
            end
            if (j == 1) begin
                m1_req = 1'b1; m1_addr = 32'h2000_0080;
            end
            s_rdata = 32'hA000_0000 + 32'(j);
            #1;
            if (j < 3) begin
                chk1("t4_b_m0_gnt", b_m0_gnt, j != 1);
                chk1("t4_b_m1_gnt", b_m1_gnt, j == 1);
            end
            if (j > 0) begin
                chk1("t4_b_m0_rvalid", b_m0_rvalid, (j == 3) || (j == 5));
                chk1("t4_b_m1_rvalid", b_m1_rvalid, j == 4);
                chk1("t4_a_m0_rvalid", a_m0_rvalid, (j == 1) || (j == 3));
                chk1("t4_a_m1_rvalid", a_m1_rvalid, j == 2);
            end
            if (j == 4) chk32("t4_b_m1_rdata", b_m1_rdata, 32'hA000_0004);
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Reset one cycle before latency-3 data returns; lock must clear too
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h2000_0004;
        cycle();
        idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 32'h2000_0000;
        #1;
        chk1("t5_lock_b_m1_gnt", b_m1_gnt, 1'b1);
        chk1("t5_a_m0_rvalid", a_m0_rvalid, 1'b1);
        cycle();
        rst = 1'b1;
        m0_req = 1'b1; m1_we = 1'b0;
        #1;
        chk1("t5_rst_a_m0_gnt", a_m0_gnt, 1'b0);
        chk1("t5_rst_a_m1_gnt", a_m1_gnt, 1'b0);
        chk1("t5_rst_b_m1_gnt", b_m1_gnt, 1'b0);
        chk1("t5_rst_b_read_en", b_s_read_en, 1'b0);
        chk1("t5_rst_b_we", b_s_we, 1'b0);
        chk1("t5_rst_b_m0_rvalid", b_m0_rvalid, 1'b0);
        cycle();
        rst = 1'b0;
        #1;
        chk1("t5_post_b_m0_rvalid", b_m0_rvalid, 1'b0);
        chk1("t5_post_a_m0_gnt", a_m0_gnt, 1'b1);
        chk1("t5_post_a_m1_gnt", a_m1_gnt, 1'b0);
        chk1("t5_post_b_m0_gnt", b_m0_gnt, 1'b1);
        cycle();
        idle();
        #1;
        chk1("t5_late_b_m0_rvalid", b_m0_rvalid, 1'b0);
        chk1("t5_late_b_m1_rvalid", b_m1_rvalid, 1'b0);
        repeat (4) cycle();

        // Byte write never produces a read response
        m0_req = 1'b1; m0_we = 1'b1; m0_width = WIDTH_BYTE;
        m0_addr = 32'h2000_0003; m0_wdata = 32'h0000_00AB;
        #1;
        chk1("t6_we", a_s_we, 1'b1);
        chk1("t6_read_en", a_s_read_en, 1'b0);
        chk32("t6_width", 32'(a_s_width), 32'(WIDTH_BYTE));
        chk32("t6_addr", a_s_addr, 32'h2000_0003);
        cycle();
        idle();
        for (int j = 1; j <= 4; j++) begin
            #1;
            chk1("t6_a_m0_rvalid", a_m0_rvalid, 1'b0);
            chk1("t6_b_m0_rvalid", b_m0_rvalid, 1'b0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
